// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes, default bit timing
// and the parity helper used when a byte is loaded for transmission.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Data narrower than 8 bits is zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Restartable bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last
// cycle of each period with tick.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: one holding register in front of the shift register,
// so the next byte can be accepted while the current frame is on the line.
//
// Handshake: a byte is accepted on any rising edge where tx_valid and tx_ready are
// both high; tx_ready is simply "holding register empty". tx_data is only sampled
// on that edge, and a stalled producer keeps tx_valid high until it sees tx_ready.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done,
  output uart_tx_state_t       dbg_state
);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 txd_q, txd_d;
  logic                 tick, restart, load, shift_en;
  logic                 last_data, last_stop;

  assign last_data = (bit_idx_q == 3'(DATA_BITS - 1));
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  // Counter is held at zero while idle so START always gets a full period.
  assign restart   = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    tx_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (last_data) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else           shift_en = 1'b1;
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick && last_stop) begin
          tx_done = 1'b1;
          if (hold_full_q) begin
            state_d = ST_START;
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is computed for the state being entered so txd can be registered.
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_en ? shift_q[1] : shift_q[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
    end
  end

  // Load and accept are exclusive: load needs hold_full, accept needs it clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end else if (tx_valid && !hold_full_q) begin
      hold_q      <= tx_data;
      hold_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (load) begin
      shift_q <= hold_q;
      par_q   <= calc_parity(8'(hold_q), PARITY);
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Indices only matter inside their own state; they are cleared everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      if (state_q != ST_DATA) bit_idx_q <= '0;
      else if (tick)          bit_idx_q <= bit_idx_q + 3'd1;
      if (state_q != ST_STOP) stop_idx_q <= 1'b0;
      else if (tick)          stop_idx_q <= ~stop_idx_q;
    end
  end

  assign tx_ready  = !hold_full_q;
  assign txd       = txd_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: three configurations driven by random bytes, every frame
// rebuilt from the byte and the framing rules and compared on the line cycle by cycle.
module tb_uart_tx_buf;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           valid_v [3];
  logic [7:0]     data_v  [3];
  logic           ready_v [3];
  logic           txd_v   [3];
  logic           busy_v  [3];
  logic           done_v  [3];
  uart_tx_state_t st_v    [3];

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  uart_tx_buf #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]),
    .dbg_state(st_v[0]));

  uart_tx_buf #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]),
    .dbg_state(st_v[1]));

  uart_tx_buf #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY(PAR_ODD), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(data_v[2][4:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]),
    .dbg_state(st_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds tx_valid with changing junk data while stalled; the real byte is only
  // presented once tx_ready is seen, so only it may reach the line.
  task automatic send(input int id, input logic [7:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    valid_v[id] = 1'b1;
    data_v[id]  = 8'($urandom);
    while (ready_v[id] !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      data_v[id] = 8'($urandom);
      waited++;
    end
    if (waited >= 5000) begin
      check($sformatf("dut%0d ready_timeout", id), 32'(waited), 32'd0);
      valid_v[id] = 1'b0;
      return;
    end
    data_v[id] = d;
    @(posedge clk);
    exp_q.push_back(d);
    #1;
    valid_v[id] = 1'b0;
    data_v[id]  = 8'($urandom);
  endtask

  // Waits for a start bit, then checks the whole frame against the expected byte.
  task automatic mon_frame(input int id, input int cpb, input int db, input int par,
                           input int nstop, output int gap, output logic obs_par);
    logic [7:0] d;
    logic       bits[$];
    logic       p;
    int         good, done_cnt, done_pos, busy_cnt, len;
    gap = 0;
    obs_par = 1'bx;
    while (gap < 3000) begin
      @(negedge clk);
      gap++;
      if (txd_v[id] === 1'b0) break;
    end
    if (txd_v[id] !== 1'b0) begin
      check($sformatf("dut%0d start_timeout", id), 32'(txd_v[id]), 32'd0);
      return;
    end
    if (exp_q.size() == 0) begin
      check($sformatf("dut%0d unexpected_frame", id), 32'd1, 32'd0);
      return;
    end
    d = exp_q.pop_front();
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (par == PAR_ODD)  bits.push_back(~p);
    if (par == PAR_EVEN) bits.push_back(p);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    len = bits.size() * cpb;
    done_cnt = 0;
    done_pos = -1;
    busy_cnt = 0;
    for (int b = 0; b < bits.size(); b++) begin
      good = 0;
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (txd_v[id] === bits[b]) good++;
        if (busy_v[id] === 1'b1) busy_cnt++;
        if (done_v[id] === 1'b1) begin
          done_cnt++;
          if (done_pos < 0) done_pos = b * cpb + c;
        end
        if (par != PAR_NONE && b == db + 1 && c == cpb / 2) obs_par = txd_v[id];
      end
      check($sformatf("dut%0d byte %02h bit%0d cycles", id, d, b), 32'(good), 32'(cpb));
    end
    check($sformatf("dut%0d byte %02h busy_cycles", id, d), 32'(busy_cnt), 32'(len));
    check($sformatf("dut%0d byte %02h done_count", id, d), 32'(done_cnt), 32'd1);
    check($sformatf("dut%0d byte %02h done_pos", id, d), 32'(done_pos), 32'(len - 1));
  endtask

  task automatic run_random(input int id, input int cpb, input int db, input int par,
                            input int nstop, input int n);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(id, 8'($urandom));
        end
      end
      begin
        int   g;
        logic pb;
        for (int i = 0; i < n; i++) mon_frame(id, cpb, db, par, nstop, g, pb);
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g1, g2, low_cnt;
    logic pb;
    for (int i = 0; i < 3; i++) begin
      valid_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d reset txd", i), 32'(txd_v[i]), 32'd1);
      check($sformatf("dut%0d reset busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("dut%0d reset ready", i), 32'(ready_v[i]), 32'd1);
      check($sformatf("dut%0d reset done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("dut%0d reset state", i), 32'(st_v[i]), 32'(ST_IDLE));
    end
    reset = 1'b0;

    // Basic frame with accept-to-line latency
    fork
      begin
        send(0, 8'hA5);
        check("lat accept_edge txd", 32'(txd_v[0]), 32'd1);
        check("lat accept_edge busy", 32'(busy_v[0]), 32'd0);
        check("lat accept_edge ready", 32'(ready_v[0]), 32'd0);
        @(posedge clk);
        #1;
        check("lat next_edge txd", 32'(txd_v[0]), 32'd0);
        check("lat next_edge busy", 32'(busy_v[0]), 32'd1);
        check("lat next_edge ready", 32'(ready_v[0]), 32'd1);
      end
      mon_frame(0, 16, 8, PAR_NONE, 1, g1, pb);
    join

    // Back-to-back: second frame must start in the cycle right after the first ends
    fork
      begin
        send(0, 8'h00);
        send(0, 8'hFF);
        check("b2b ready_after_second", 32'(ready_v[0]), 32'd0);
      end
      begin
        mon_frame(0, 16, 8, PAR_NONE, 1, g1, pb);
        mon_frame(0, 16, 8, PAR_NONE, 1, g2, pb);
        check("b2b gap", 32'(g2), 32'd1);
      end
    join

    // Parity values on 0x07
    fork
      send(1, 8'h07);
      mon_frame(1, 16, 8, PAR_EVEN, 1, g1, pb);
    join
    check("even parity 07", 32'(pb), 32'd1);
    fork
      send(2, 8'h07);
      mon_frame(2, 2, 5, PAR_ODD, 2, g1, pb);
    join
    check("odd parity 07", 32'(pb), 32'd0);

    // Reset during data bit 3 with a second byte waiting in the holding register
    send(0, 8'hC3);
    send(0, 8'h11);
    repeat (70) @(negedge clk);
    check("mid_frame txd data bit3", 32'(txd_v[0]), 32'd0);
    check("mid_frame busy", 32'(busy_v[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("async reset txd", 32'(txd_v[0]), 32'd1);
    check("async reset busy", 32'(busy_v[0]), 32'd0);
    check("async reset ready", 32'(ready_v[0]), 32'd1);
    check("async reset done", 32'(done_v[0]), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    low_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd_v[0] !== 1'b1) low_cnt++;
    end
    check("post_reset line quiet", 32'(low_cnt), 32'd0);
    fork
      send(0, 8'h5A);
      mon_frame(0, 16, 8, PAR_NONE, 1, g1, pb);
    join

    // Randomized traffic on all three configurations
    run_random(0, 16, 8, PAR_NONE, 1, 10);
    run_random(1, 16, 8, PAR_EVEN, 1, 10);
    run_random(2, 2, 5, PAR_ODD, 2, 30);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
